// File: rtl/ir_nec_pkg.sv
// Shared NEC IR definitions: decoder state encoding, default pulse-width
// windows (clock cycles at 50 MHz) and small helpers for receiver and benches.
package ir_nec_pkg;

  localparam int unsigned CNT_W = 20;

  localparam int unsigned LEADER_MARK_MIN_DEF  = 400000;
  localparam int unsigned LEADER_MARK_MAX_DEF  = 500000;
  localparam int unsigned LEADER_SPACE_MIN_DEF = 200000;
  localparam int unsigned LEADER_SPACE_MAX_DEF = 250000;
  localparam int unsigned REPEAT_SPACE_MIN_DEF = 100000;
  localparam int unsigned REPEAT_SPACE_MAX_DEF = 125000;
  localparam int unsigned BIT_MARK_MIN_DEF     = 20000;
  localparam int unsigned BIT_MARK_MAX_DEF     = 35000;
  localparam int unsigned ZERO_SPACE_MIN_DEF   = 20000;
  localparam int unsigned ZERO_SPACE_MAX_DEF   = 35000;
  localparam int unsigned ONE_SPACE_MIN_DEF    = 70000;
  localparam int unsigned ONE_SPACE_MAX_DEF    = 100000;

  // Nominal durations, handy for a transmitter model.
  localparam int unsigned LEADER_MARK_NOM  = 450000;
  localparam int unsigned LEADER_SPACE_NOM = 225000;
  localparam int unsigned REPEAT_SPACE_NOM = 112500;
  localparam int unsigned BIT_MARK_NOM     = 28125;
  localparam int unsigned ZERO_SPACE_NOM   = 28125;
  localparam int unsigned ONE_SPACE_NOM    = 84375;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK
  } state_e;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic in_win(input int unsigned c, input int unsigned lo,
                                  input int unsigned hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/ir_receiver_nec_edge_sync.sv
// Two-flop synchronizer plus history flop for the IR pin; flags synchronized
// falling (mark start) and rising (mark end) transitions.
module ir_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;

  always_comb begin
    sync1_d = ir_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Idle line is high, so resetting to 1 avoids a spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign level = sync2_q;
  assign fall  = hist_q & ~sync2_q;
  assign rise  = ~hist_q & sync2_q;

endmodule

// File: rtl/ir_receiver_nec.sv
// NEC infrared frame decoder: measures mark/space widths with a level counter
// and walks leader, 32 data bits and stop mark, reporting data/repeat/error.
module ir_receiver_nec
  import ir_nec_pkg::*;
#(
  parameter int unsigned LEADER_MARK_MIN  = LEADER_MARK_MIN_DEF,
  parameter int unsigned LEADER_MARK_MAX  = LEADER_MARK_MAX_DEF,
  parameter int unsigned LEADER_SPACE_MIN = LEADER_SPACE_MIN_DEF,
  parameter int unsigned LEADER_SPACE_MAX = LEADER_SPACE_MAX_DEF,
  parameter int unsigned REPEAT_SPACE_MIN = REPEAT_SPACE_MIN_DEF,
  parameter int unsigned REPEAT_SPACE_MAX = REPEAT_SPACE_MAX_DEF,
  parameter int unsigned BIT_MARK_MIN     = BIT_MARK_MIN_DEF,
  parameter int unsigned BIT_MARK_MAX     = BIT_MARK_MAX_DEF,
  parameter int unsigned ZERO_SPACE_MIN   = ZERO_SPACE_MIN_DEF,
  parameter int unsigned ZERO_SPACE_MAX   = ZERO_SPACE_MAX_DEF,
  parameter int unsigned ONE_SPACE_MIN    = ONE_SPACE_MIN_DEF,
  parameter int unsigned ONE_SPACE_MAX    = ONE_SPACE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       rpt,
  output logic       err,
  output logic       busy
);

  localparam int unsigned LEAD_SPACE_LIM = umax(LEADER_SPACE_MAX, REPEAT_SPACE_MAX);
  localparam int unsigned BIT_SPACE_LIM  = umax(ZERO_SPACE_MAX, ONE_SPACE_MAX);

  logic level, fall, rise;
  logic mark_start, mark_end;

  ir_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ir_in (ir_in),
    .level (level),
    .fall  (fall),
    .rise  (rise)
  );

  assign mark_start = fall & ~level;
  assign mark_end   = rise & level;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  int unsigned      cnt32;

  always_comb begin
    if (fall | rise) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cnt32 = 32'(cnt_q);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic        rep_flag_q, rep_flag_d;
  logic        good_q, good_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        valid_q, valid_d;
  logic        rpt_q, rpt_d;
  logic        err_q, err_d;

  int unsigned limit;
  logic        timeout;
  logic        frame_ok;

  always_comb begin
    case (state_q)
      ST_LEAD_MARK:  limit = LEADER_MARK_MAX;
      ST_LEAD_SPACE: limit = LEAD_SPACE_LIM;
      ST_BIT_MARK:   limit = BIT_MARK_MAX;
      ST_BIT_SPACE:  limit = BIT_SPACE_LIM;
      ST_STOP_MARK:  limit = BIT_MARK_MAX;
      default:       limit = '1;
    endcase
  end

  assign timeout  = (state_q != ST_IDLE) && (cnt32 > limit);
  assign frame_ok = (word_q[23:16] == ~word_q[31:24]) && (word_q[7:0] == ~word_q[15:8]);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_idx_d  = bit_idx_q;
    rep_flag_d = rep_flag_q;
    good_d     = good_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    valid_d    = 1'b0;
    rpt_d      = 1'b0;
    err_d      = 1'b0;

    // Timeout wins over any edge in the same cycle; that edge is consumed.
    if (timeout) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mark_start) begin
            state_d    = ST_LEAD_MARK;
            rep_flag_d = 1'b0;
          end
        end

        ST_LEAD_MARK: begin
          if (mark_end) begin
            if (in_win(cnt32, LEADER_MARK_MIN, LEADER_MARK_MAX)) begin
              state_d = ST_LEAD_SPACE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end

        ST_LEAD_SPACE: begin
          if (mark_start) begin
            if (in_win(cnt32, LEADER_SPACE_MIN, LEADER_SPACE_MAX)) begin
              state_d   = ST_BIT_MARK;
              bit_idx_d = '0;
            end else if (in_win(cnt32, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX)) begin
              state_d    = ST_STOP_MARK;
              rep_flag_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end

        ST_BIT_MARK: begin
          if (mark_end) begin
            if (in_win(cnt32, BIT_MARK_MIN, BIT_MARK_MAX)) begin
              state_d = ST_BIT_SPACE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end

        ST_BIT_SPACE: begin
          if (mark_start) begin
            if (in_win(cnt32, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                in_win(cnt32, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
              word_d    = {word_q[30:0], in_win(cnt32, ONE_SPACE_MIN, ONE_SPACE_MAX)};
              bit_idx_d = bit_idx_q + 5'd1;
              state_d   = (bit_idx_q == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end

        ST_STOP_MARK: begin
          if (mark_end) begin
            state_d = ST_IDLE;
            if (!in_win(cnt32, BIT_MARK_MIN, BIT_MARK_MAX)) begin
              err_d = 1'b1;
            end else if (rep_flag_q) begin
              rpt_d = good_q;
            end else if (frame_ok) begin
              addr_d  = word_q[31:24];
              cmd_d   = word_q[15:8];
              valid_d = 1'b1;
              good_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      word_q     <= '0;
      bit_idx_q  <= '0;
      rep_flag_q <= 1'b0;
      good_q     <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= '0;
      valid_q    <= 1'b0;
      rpt_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      word_q     <= word_d;
      bit_idx_q  <= bit_idx_d;
      rep_flag_q <= rep_flag_d;
      good_q     <= good_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      rpt_q      <= rpt_d;
      err_q      <= err_d;
    end
  end

  assign addr  = addr_q;
  assign cmd   = cmd_q;
  assign valid = valid_q;
  assign rpt   = rpt_q;
  assign err   = err_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_receiver_nec.sv
// Self-checking bench for ir_receiver_nec with timing windows scaled 1/1000
// so whole frames take a few thousand cycles.
module tb_ir_receiver_nec;

  localparam int LM = 450;
  localparam int LS = 225;
  localparam int RS = 112;
  localparam int BM = 28;
  localparam int ZS = 28;
  localparam int OS = 84;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir_in = 1'b1;
  logic [7:0] addr, cmd;
  logic       valid, rpt, err, busy;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0, n_rpt = 0, n_err = 0;
  int cyc = 0, last_err_cyc = 0;
  logic prev_pulse = 1'b0;

  always #5 clk = ~clk;

  ir_receiver_nec #(
    .LEADER_MARK_MIN  (400), .LEADER_MARK_MAX  (500),
    .LEADER_SPACE_MIN (200), .LEADER_SPACE_MAX (250),
    .REPEAT_SPACE_MIN (100), .REPEAT_SPACE_MAX (125),
    .BIT_MARK_MIN     (20),  .BIT_MARK_MAX     (35),
    .ZERO_SPACE_MIN   (20),  .ZERO_SPACE_MAX   (35),
    .ONE_SPACE_MIN    (70),  .ONE_SPACE_MAX    (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ir_in (ir_in),
    .addr  (addr),
    .cmd   (cmd),
    .valid (valid),
    .rpt   (rpt),
    .err   (err),
    .busy  (busy)
  );

  always @(posedge clk) cyc++;

  // Pulse monitor: tallies strobes and enforces one-at-a-time, never back-to-back.
  always @(negedge clk) begin
    if (valid || rpt || err) begin
      vectors++;
      if ((int'(valid) + int'(rpt) + int'(err)) != 1 || prev_pulse) begin
        miscompares++;
        $display("FAIL pulse_excl: valid=%b rpt=%b err=%b prev=%b, required exactly one and not consecutive",
                 valid, rpt, err, prev_pulse);
      end
      n_valid += int'(valid);
      n_rpt   += int'(rpt);
      n_err   += int'(err);
      if (err) last_err_cyc = cyc;
    end
    prev_pulse = valid | rpt | err;
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    ir_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  function automatic int jit(input int nom, input int pct);
    return nom + (nom * pct) / 100;
  endfunction

  function automatic int rj();
    return int'($urandom_range(0, 16)) - 8;
  endfunction

  // Transmitter model: spaces use pct unless rnd, where every segment jitters.
  task automatic send(input bit is_rpt, input logic [31:0] w, input int pct, input bit rnd);
    hold(1'b0, rnd ? jit(LM, rj()) : LM);
    if (is_rpt) begin
      hold(1'b1, rnd ? jit(RS, rj()) : RS);
    end else begin
      hold(1'b1, rnd ? jit(LS, rj()) : LS);
      for (int i = 31; i >= 0; i--) begin
        hold(1'b0, rnd ? jit(BM, rj()) : BM);
        hold(1'b1, jit(w[i] ? OS : ZS, rnd ? rj() : pct));
      end
    end
    hold(1'b0, rnd ? jit(BM, rj()) : BM);
    hold(1'b1, 40);
  endtask

  task automatic run_chk(input string tag, input bit is_rpt, input logic [31:0] w,
                         input int pct, input bit rnd, input int ev, input int er,
                         input int ee, input logic [7:0] ea, input logic [7:0] ec);
    int v0, r0, e0;
    v0 = n_valid; r0 = n_rpt; e0 = n_err;
    send(is_rpt, w, pct, rnd);
    chk({tag, "_valid"}, n_valid - v0, ev);
    chk({tag, "_rpt"},   n_rpt - r0,   er);
    chk({tag, "_err"},   n_err - e0,   ee);
    chk({tag, "_addr"},  int'(addr),   int'(ea));
    chk({tag, "_cmd"},   int'(cmd),    int'(ec));
  endtask

  typedef struct {
    bit          is_rpt;
    logic [31:0] word;
    int          pct;
    int          e_valid, e_rpt, e_err;
    logic [7:0]  e_addr, e_cmd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int e0, t0;
    bit   m_good;
    logic [7:0] m_addr, m_cmd;

    tbl[0] = '{1'b1, 32'h0,        0,   0, 0, 0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 32'h5AA53CC3, 0,   1, 0, 0, 8'h5A, 8'h3C};
    tbl[2] = '{1'b1, 32'h0,        0,   0, 1, 0, 8'h5A, 8'h3C};
    tbl[3] = '{1'b0, 32'h5AA53CC2, 0,   0, 0, 1, 8'h5A, 8'h3C};
    tbl[4] = '{1'b0, 32'h10EF20DF, -10, 1, 0, 0, 8'h10, 8'h20};
    tbl[5] = '{1'b0, 32'h11EE21DE, 10,  1, 0, 0, 8'h11, 8'h21};

    repeat (3) @(negedge clk);
    chk("rst_addr",  int'(addr),  0);
    chk("rst_cmd",   int'(cmd),   0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_pulse", int'({valid, rpt, err}), 0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    for (int i = 0; i < 6; i++) begin
      run_chk($sformatf("tbl%0d", i), tbl[i].is_rpt, tbl[i].word, tbl[i].pct, 1'b0,
              tbl[i].e_valid, tbl[i].e_rpt, tbl[i].e_err, tbl[i].e_addr, tbl[i].e_cmd);
    end

    // Short (7 ms) leader: error only once the mark ends.
    e0 = n_err;
    hold(1'b0, 350);
    chk("short_lead_busy", int'(busy), 1);
    chk("short_lead_noerr_during", n_err - e0, 0);
    hold(1'b1, 20);
    chk("short_lead_err", n_err - e0, 1);
    chk("short_lead_busy_after", int'(busy), 0);

    // Line stuck low 12 ms: error once the leader-mark maximum is exceeded.
    e0 = n_err;
    t0 = cyc;
    hold(1'b0, 600);
    chk("stuck_low_err", n_err - e0, 1);
    chk("stuck_low_err_time_ok",
        int'((last_err_cyc - t0) >= 500 && (last_err_cyc - t0) <= 512), 1);
    hold(1'b1, 50);
    chk("stuck_low_release_quiet", n_err - e0, 1);
    chk("stuck_low_addr_kept", int'(addr), 8'h11);

    // Reset during bit 15 discards the frame silently.
    e0 = n_err;
    hold(1'b0, LM);
    hold(1'b1, LS);
    for (int i = 0; i < 15; i++) begin
      hold(1'b0, BM);
      hold(1'b1, (i % 2 == 1) ? OS : ZS);
    end
    hold(1'b0, BM);
    hold(1'b1, 10);
    rst_n = 1'b0;
    hold(1'b1, 2);
    chk("midrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    hold(1'b1, 120);
    chk("midrst_noerr", n_err - e0, 0);
    chk("midrst_addr", int'(addr), 0);
    chk("midrst_cmd",  int'(cmd),  0);
    run_chk("post_rst", 1'b0, 32'h01FEFE01, 0, 1'b0, 1, 0, 0, 8'h01, 8'hFE);

    // Randomized frames against the reference model.
    m_good = 1'b1;
    m_addr = 8'h01;
    m_cmd  = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      int unsigned kind;
      logic [7:0]  a, c;
      logic [31:0] w;
      bit          ok;
      kind = $urandom_range(0, 3);
      a = 8'($urandom);
      c = 8'($urandom);
      w = {a, ~a, c, ~c};
      if (kind == 1) w[$urandom_range(0, 31)] ^= 1'b1;
      ok = (w[23:16] == ~w[31:24]) && (w[7:0] == ~w[15:8]);
      if (kind == 0) begin
        run_chk($sformatf("rnd%0d_rep", i), 1'b1, w, 0, 1'b1,
                0, int'(m_good), 0, m_addr, m_cmd);
      end else if (ok) begin
        m_good = 1'b1;
        m_addr = w[31:24];
        m_cmd  = w[15:8];
        run_chk($sformatf("rnd%0d_data", i), 1'b0, w, 0, 1'b1, 1, 0, 0, m_addr, m_cmd);
      end else begin
        run_chk($sformatf("rnd%0d_bad", i), 1'b0, w, 0, 1'b1, 0, 0, 1, m_addr, m_cmd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
